alu_ctrl_seq: RTL and testbench

Registered, parametrised successor to the multicycle CPU's combinational ALU-control decoder. Decodes opcode, FSM state, FUNCT3 and FUNCT7 into a 5-bit ALU operation code. Adds a sequencer that holds the code and stalls the main FSM for multi-cycle RV32M multiply/divide ops. Sits between the main control FSM and the ALU/muldiv datapath.

---
 rtl/alu_ctrl_seq.sv | 250 +++++++++++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU-control decoder with a multi-cycle sequencer.
//
// Decodes the main-FSM state, opcode, FUNCT3 and FUNCT7 into a 5-bit ALU
// operation code. RV32M multiply/divide ops hold the code and stall the main
// FSM through BUSY for MUL_CYC or DIV_CYC cycles.
//
// Optional feature macro: RV32M_EN
//   defined   - M-group decode plus the IDLE/RUN sequencer and down-counter.
//   undefined - M-group requests decode as illegal, BUSY is tied 0.
//
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   synchronous active-high reset
//   VALID      in   decode request, sampled when not BUSY
//   OPCODE     in   instruction[6:0]
//   STATE      in   main-FSM state code
//   FUNCT3     in   instruction[14:12]
//   FUNCT7     in   instruction[31:25]
//   CONTROLOUT out  registered ALU operation code (bit 4 = RV32M group)
//   BUSY       out  multi-cycle op in progress
//   DONE       out  one-cycle pulse, CONTROLOUT valid and op complete
//   ILLEGAL    out  one-cycle pulse with DONE for an undecodable request
module alu_ctrl_seq #(
    parameter int unsigned STW     = 4,
    parameter int unsigned OPW     = 5,
    parameter int unsigned MUL_CYC = 4,
    parameter int unsigned DIV_CYC = 32,
    parameter int unsigned CNTW    = 6
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           VALID,
    input  logic [6:0]     OPCODE,
    input  logic [STW-1:0] STATE,
    input  logic [2:0]     FUNCT3,
    input  logic [6:0]     FUNCT7,
    output logic [OPW-1:0] CONTROLOUT,
    output logic           BUSY,
    output logic           DONE,
    output logic           ILLEGAL
);

    // Elaboration-time guard on the configuration.
    if (OPW < 5 || MUL_CYC < 1 || DIV_CYC < 1 ||
        MUL_CYC > (1 << CNTW) || DIV_CYC > (1 << CNTW)) begin : g_bad_cfg
        $error("alu_ctrl_seq: invalid parameter combination");
    end

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_SRL = 5'b00110;
    localparam logic [4:0] ALU_SRA = 5'b00111;

    // Base integer table shared by R-type (FUNCT7=0) and I-type ALU ops.
    function automatic logic [4:0] base_op(input logic [2:0] f3);
        logic [4:0] op;
        case (f3)
            3'b000:  op = 5'b00000;
            3'b001:  op = 5'b00010;
            3'b010:  op = 5'b00011;
            3'b011:  op = 5'b00100;
            3'b100:  op = 5'b00101;
            3'b101:  op = 5'b00110;
            3'b110:  op = 5'b01000;
            default: op = 5'b01001;
        endcase
        return op;
    endfunction

    // ---------------------------------------------------------------- decode
    logic [4:0] dec_op;
    logic       dec_ill;
`ifdef RV32M_EN
    logic       dec_multi;
`endif

    // dec_op stays ALU_ADD (zero) on every illegal path.
    always_comb begin
        dec_op  = ALU_ADD;
        dec_ill = 1'b0;
`ifdef RV32M_EN
        dec_multi = 1'b0;
`endif
        case (STATE)
            STW'(1), STW'(2), STW'(3), STW'(8), STW'(11): dec_op = ALU_ADD;
            STW'(5): begin
                if (OPCODE == OP_LOAD || OPCODE == OP_STORE) begin
                    dec_op = ALU_ADD;
                end else if (OPCODE == OP_IMM) begin
                    if (FUNCT3 == 3'b101) begin
                        if (FUNCT7 == F7_BASE)     dec_op  = ALU_SRL;
                        else if (FUNCT7 == F7_ALT) dec_op  = ALU_SRA;
                        else                       dec_ill = 1'b1;
                    end else if (FUNCT3 == 3'b001 && FUNCT7 != F7_BASE) begin
                        dec_ill = 1'b1;
                    end else begin
                        // FUNCT7 is immediate data for the remaining I-type ops.
                        dec_op = base_op(FUNCT3);
                    end
                end else begin
                    dec_ill = 1'b1;
                end
            end
            STW'(7): begin
                if (OPCODE == OP_REG) begin
                    case (FUNCT7)
                        F7_BASE: dec_op = base_op(FUNCT3);
                        F7_ALT: begin
                            if (FUNCT3 == 3'b000)      dec_op  = ALU_SUB;
                            else if (FUNCT3 == 3'b101) dec_op  = ALU_SRA;
                            else                       dec_ill = 1'b1;
                        end
`ifdef RV32M_EN
                        F7_MULDIV: begin
                            dec_op    = {2'b10, FUNCT3};
                            dec_multi = 1'b1;
                        end
`endif
                        default: dec_ill = 1'b1;
                    endcase
                end else begin
                    dec_ill = 1'b1;
                end
            end
            STW'(9): begin
                if (OPCODE == OP_BRANCH) begin
                    case (FUNCT3)
                        3'b000:  dec_op  = 5'b01010;
                        3'b001:  dec_op  = 5'b01011;
                        3'b100:  dec_op  = 5'b01100;
                        3'b101:  dec_op  = 5'b01101;
                        3'b110:  dec_op  = 5'b01110;
                        3'b111:  dec_op  = 5'b01111;
                        default: dec_ill = 1'b1;
                    endcase
                end else begin
                    dec_ill = 1'b1;
                end
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // ------------------------------------------------------------- sequencer
    logic [OPW-1:0] ctrl_q, ctrl_d;
    logic           done_q, done_d;
    logic           illegal_q, illegal_d;

`ifdef RV32M_EN
    typedef enum logic [0:0] {StIdle, StRun} state_e;
    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            ctrl_q    <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (VALID) begin
                    ctrl_d = OPW'(dec_op);
                    if (dec_multi) begin
                        // Opcode bit 2 separates DIV/DIVU/REM/REMU from the multiplies.
                        state_d = StRun;
                        cnt_d   = dec_op[2] ? CNTW'(DIV_CYC - 1) : CNTW'(MUL_CYC - 1);
                    end else begin
                        done_d    = 1'b1;
                        illegal_d = dec_ill;
                    end
                end
            end
            StRun: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        CONTROLOUT = ctrl_q;
        BUSY       = (state_q == StRun);
        DONE       = done_q;
        ILLEGAL    = illegal_q;
    end
`else
    always_ff @(posedge CLK) begin
        if (RST) begin
            ctrl_q    <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        ctrl_d    = ctrl_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        if (VALID) begin
            ctrl_d    = OPW'(dec_op);
            done_d    = 1'b1;
            illegal_d = dec_ill;
        end
    end

    always_comb begin
        CONTROLOUT = ctrl_q;
        BUSY       = 1'b0;
        DONE       = done_q;
        ILLEGAL    = illegal_q;
    end
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed self-checking bench for alu_ctrl_seq (default parameters).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_alu_ctrl_seq;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    logic       CLK = 1'b0;
    logic       RST;
    logic       VALID;
    logic [6:0] OPCODE;
    logic [3:0] STATE;
    logic [2:0] FUNCT3;
    logic [6:0] FUNCT7;
    logic [4:0] CONTROLOUT;
    logic       BUSY;
    logic       DONE;
    logic       ILLEGAL;

    int n_pass  = 0;
    int n_total = 0;

    alu_ctrl_seq dut (
        .CLK        (CLK),
        .RST        (RST),
        .VALID      (VALID),
        .OPCODE     (OPCODE),
        .STATE      (STATE),
        .FUNCT3     (FUNCT3),
        .FUNCT7     (FUNCT7),
        .CONTROLOUT (CONTROLOUT),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .ILLEGAL    (ILLEGAL)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] st, input logic [6:0] op,
                         input logic [2:0] f3, input logic [6:0] f7);
        VALID  = v;
        STATE  = st;
        OPCODE = op;
        FUNCT3 = f3;
        FUNCT7 = f7;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        drive(1'b1, 4'd7, OP_REG, 3'b000, F7_ALT);
        tick();
        tick();
        n_total++; if (CONTROLOUT !== 5'b00000) $display("FAIL reset_ctrl: got %b want 00000", CONTROLOUT); else n_pass++;
        n_total++; if (BUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", BUSY); else n_pass++;
        n_total++; if (DONE !== 1'b0) $display("FAIL reset_done: got %b want 0", DONE); else n_pass++;
        n_total++; if (ILLEGAL !== 1'b0) $display("FAIL reset_illegal: got %b want 0", ILLEGAL); else n_pass++;
        RST = 1'b0;
        VALID = 1'b0;
        tick();
    endtask

    task automatic test_rtype();
        drive(1'b1, 4'd7, OP_REG, 3'b000, F7_ALT);
        tick();
        n_total++; if (CONTROLOUT !== 5'b00001) $display("FAIL sub_ctrl: got %b want 00001", CONTROLOUT); else n_pass++;
        n_total++; if (DONE !== 1'b1) $display("FAIL sub_done: got %b want 1", DONE); else n_pass++;
        n_total++; if (BUSY !== 1'b0) $display("FAIL sub_busy: got %b want 0", BUSY); else n_pass++;
        n_total++; if (ILLEGAL !== 1'b0) $display("FAIL sub_illegal: got %b want 0", ILLEGAL); else n_pass++;
        drive(1'b1, 4'd7, OP_REG, 3'b001, F7_BASE);
        tick();
        n_total++; if (CONTROLOUT !== 5'b00010) $display("FAIL sll_ctrl: got %b want 00010", CONTROLOUT); else n_pass++;
        drive(1'b1, 4'd7, OP_REG, 3'b111, F7_BASE);
        tick();
        n_total++; if (CONTROLOUT !== 5'b01001) $display("FAIL and_ctrl: got %b want 01001", CONTROLOUT); else n_pass++;
        drive(1'b1, 4'd7, OP_REG, 3'b101, F7_ALT);
        tick();
        n_total++; if (CONTROLOUT !== 5'b00111) $display("FAIL sra_ctrl: got %b want 00111", CONTROLOUT); else n_pass++;
        drive(1'b1, 4'd7, OP_REG, 3'b010, F7_ALT);
        tick();
        n_total++; if (CONTROLOUT !== 5'b00000) $display("FAIL alt_bad_ctrl: got %b want 00000", CONTROLOUT); else n_pass++;
        n_total++; if (ILLEGAL !== 1'b1) $display("FAIL alt_bad_illegal: got %b want 1", ILLEGAL); else n_pass++;
        n_total++; if (DONE !== 1'b1) $display("FAIL alt_bad_done: got %b want 1", DONE); else n_pass++;
        VALID = 1'b0;
        tick();
    endtask

    task automatic test_hold();
        drive(1'b1, 4'd7, OP_REG, 3'b111, F7_BASE);
        tick();
        drive(1'b0, 4'd9, OP_BRANCH, 3'b010, F7_BASE);
        tick();
        n_total++; if (CONTROLOUT !== 5'b01001) $display("FAIL hold_ctrl: got %b want 01001", CONTROLOUT); else n_pass++;
        n_total++; if (DONE !== 1'b0) $display("FAIL hold_done: got %b want 0", DONE); else n_pass++;
        n_total++; if (ILLEGAL !== 1'b0) $display("FAIL hold_illegal: got %b want 0", ILLEGAL); else n_pass++;
        tick();
        n_total++; if (CONTROLOUT !== 5'b01001) $display("FAIL hold2_ctrl: got %b want 01001", CONTROLOUT); else n_pass++;
    endtask

    task automatic test_branch();
        drive(1'b1, 4'd9, OP_BRANCH, 3'b110, F7_BASE);
        tick();
        n_total++; if (CONTROLOUT !== 5'b01110) $display("FAIL bltu_ctrl: got %b want 01110", CONTROLOUT); else n_pass++;
        n_total++; if (ILLEGAL !== 1'b0) $display("FAIL bltu_illegal: got %b want 0", ILLEGAL); else n_pass++;
        drive(1'b1, 4'd9, OP_BRANCH, 3'b010, F7_BASE);
        tick();
        n_total++; if (CONTROLOUT !== 5'b00000) $display("FAIL br010_ctrl: got %b want 00000", CONTROLOUT); else n_pass++;
        n_total++; if (ILLEGAL !== 1'b1) $display("FAIL br010_illegal: got %b want 1", ILLEGAL); else n_pass++;
        n_total++; if (DONE !== 1'b1) $display("FAIL br010_done: got %b want 1", DONE); else n_pass++;
        drive(1'b1, 4'd9, OP_BRANCH, 3'b101, F7_BASE);
        tick();
        n_total++; if (CONTROLOUT !== 5'b01101) $display("FAIL bge_ctrl: got %b want 01101", CONTROLOUT); else n_pass++;
        drive(1'b1, 4'd9, OP_REG, 3'b000, F7_BASE);
        tick();
        n_total++; if (ILLEGAL !== 1'b1) $display("FAIL s9_badop_illegal: got %b want 1", ILLEGAL); else n_pass++;
        n_total++; if (CONTROLOUT !== 5'b00000) $display("FAIL s9_badop_ctrl: got %b want 00000", CONTROLOUT); else n_pass++;
        VALID = 1'b0;
        tick();
    endtask

    task automatic test_itype();
        drive(1'b1, 4'd5, OP_IMM, 3'b101, F7_ALT);
        tick();
        n_total++; if (CONTROLOUT !== 5'b00111) $display("FAIL srai_ctrl: got %b want 00111", CONTROLOUT); else n_pass++;
        n_total++; if (ILLEGAL !== 1'b0) $display("FAIL srai_illegal: got %b want 0", ILLEGAL); else n_pass++;
        drive(1'b1, 4'd5, OP_IMM, 3'b101, F7_MULDIV);
        tick();
        n_total++; if (CONTROLOUT !== 5'b00000) $display("FAIL sri_bad_ctrl: got %b want 00000", CONTROLOUT); else n_pass++;
        n_total++; if (ILLEGAL !== 1'b1) $display("FAIL sri_bad_illegal: got %b want 1", ILLEGAL); else n_pass++;
        drive(1'b1, 4'd5, OP_IMM, 3'b001, F7_BASE);
        tick();
        n_total++; if (CONTROLOUT !== 5'b00010) $display("FAIL slli_ctrl: got %b want 00010", CONTROLOUT); else n_pass++;
        drive(1'b1, 4'd5, OP_IMM, 3'b001, F7_ALT);
        tick();
        n_total++; if (ILLEGAL !== 1'b1) $display("FAIL slli_bad_illegal: got %b want 1", ILLEGAL); else n_pass++;
        drive(1'b1, 4'd5, OP_IMM, 3'b011, 7'b0101010);
        tick();
        n_total++; if (CONTROLOUT !== 5'b00100) $display("FAIL sltiu_ctrl: got %b want 00100", CONTROLOUT); else n_pass++;
        n_total++; if (ILLEGAL !== 1'b0) $display("FAIL sltiu_illegal: got %b want 0", ILLEGAL); else n_pass++;
        drive(1'b1, 4'd5, OP_LOAD, 3'b010, 7'b1111111);
        tick();
        n_total++; if (CONTROLOUT !== 5'b00000) $display("FAIL lw_ctrl: got %b want 00000", CONTROLOUT); else n_pass++;
        n_total++; if (ILLEGAL !== 1'b0) $display("FAIL lw_illegal: got %b want 0", ILLEGAL); else n_pass++;
        drive(1'b1, 4'd5, OP_REG, 3'b000, F7_BASE);
        tick();
        n_total++; if (ILLEGAL !== 1'b1) $display("FAIL s5_badop_illegal: got %b want 1", ILLEGAL); else n_pass++;
        VALID = 1'b0;
        tick();
    endtask

    task automatic test_fixed_states();
        drive(1'b1, 4'd7, OP_REG, 3'b111, F7_BASE);
        tick();
        drive(1'b1, 4'd2, 7'b1111111, 3'b011, 7'b1010101);
        tick();
        n_total++; if (CONTROLOUT !== 5'b00000) $display("FAIL id_ctrl: got %b want 00000", CONTROLOUT); else n_pass++;
        n_total++; if (ILLEGAL !== 1'b0) $display("FAIL id_illegal: got %b want 0", ILLEGAL); else n_pass++;
        n_total++; if (DONE !== 1'b1) $display("FAIL id_done: got %b want 1", DONE); else n_pass++;
        drive(1'b1, 4'd11, 7'b0000000, 3'b000, F7_BASE);
        tick();
        n_total++; if (ILLEGAL !== 1'b0) $display("FAIL s11_illegal: got %b want 0", ILLEGAL); else n_pass++;
        drive(1'b1, 4'd4, OP_REG, 3'b000, F7_BASE);
        tick();
        n_total++; if (ILLEGAL !== 1'b1) $display("FAIL s4_illegal: got %b want 1", ILLEGAL); else n_pass++;
        drive(1'b1, 4'd7, OP_LOAD, 3'b000, F7_BASE);
        tick();
        n_total++; if (ILLEGAL !== 1'b1) $display("FAIL s7_load_illegal: got %b want 1", ILLEGAL); else n_pass++;
        VALID = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [2:0] f3_tab [4];
        logic [4:0] exp_tab [4];
        f3_tab[0] = 3'b110; exp_tab[0] = 5'b01000;
        f3_tab[1] = 3'b010; exp_tab[1] = 5'b00011;
        f3_tab[2] = 3'b100; exp_tab[2] = 5'b00101;
        f3_tab[3] = 3'b101; exp_tab[3] = 5'b00110;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'd7, OP_REG, f3_tab[i], F7_BASE);
            tick();
            n_total++; if (CONTROLOUT !== exp_tab[i]) $display("FAIL b2b_ctrl[%0d]: got %b want %b", i, CONTROLOUT, exp_tab[i]); else n_pass++;
            n_total++; if (DONE !== 1'b1) $display("FAIL b2b_done[%0d]: got %b want 1", i, DONE); else n_pass++;
        end
        VALID = 1'b0;
        tick();
        n_total++; if (DONE !== 1'b0) $display("FAIL b2b_done_end: got %b want 0", DONE); else n_pass++;
    endtask

`ifdef RV32M_EN
    task automatic test_multicycle(input logic [2:0] f3, input int exp_cyc);
        int busy_cnt;
        logic [4:0] exp_op;
        exp_op = {2'b10, f3};
        drive(1'b1, 4'd7, OP_REG, f3, F7_MULDIV);
        tick();
        n_total++; if (CONTROLOUT !== exp_op) $display("FAIL m_start_ctrl: got %b want %b", CONTROLOUT, exp_op); else n_pass++;
        n_total++; if (BUSY !== 1'b1) $display("FAIL m_start_busy: got %b want 1", BUSY); else n_pass++;
        n_total++; if (DONE !== 1'b0) $display("FAIL m_start_done: got %b want 0", DONE); else n_pass++;
        busy_cnt = 1;
        // A different op is held on VALID throughout; it must be ignored.
        drive(1'b1, 4'd7, OP_REG, ~f3, F7_MULDIV);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (BUSY !== 1'b1) break;
            busy_cnt++;
            n_total++; if (CONTROLOUT !== exp_op) $display("FAIL m_run_ctrl: got %b want %b", CONTROLOUT, exp_op); else n_pass++;
            n_total++; if (DONE !== 1'b0) $display("FAIL m_run_done: got %b want 0", DONE); else n_pass++;
        end
        VALID = 1'b0;
        n_total++; if (busy_cnt !== exp_cyc) $display("FAIL m_busy_len: got %0d want %0d", busy_cnt, exp_cyc); else n_pass++;
        n_total++; if (DONE !== 1'b1) $display("FAIL m_end_done: got %b want 1", DONE); else n_pass++;
        n_total++; if (CONTROLOUT !== exp_op) $display("FAIL m_end_ctrl: got %b want %b", CONTROLOUT, exp_op); else n_pass++;
        n_total++; if (ILLEGAL !== 1'b0) $display("FAIL m_end_illegal: got %b want 0", ILLEGAL); else n_pass++;
        tick();
        n_total++; if (DONE !== 1'b0) $display("FAIL m_after_done: got %b want 0", DONE); else n_pass++;
        n_total++; if (BUSY !== 1'b0) $display("FAIL m_after_busy: got %b want 0", BUSY); else n_pass++;
    endtask

    task automatic test_mul_reset();
        int done_seen;
        drive(1'b1, 4'd7, OP_REG, 3'b000, F7_MULDIV);
        tick();
        n_total++; if (BUSY !== 1'b1) $display("FAIL mrst_busy1: got %b want 1", BUSY); else n_pass++;
        VALID = 1'b0;
        tick();
        n_total++; if (BUSY !== 1'b1) $display("FAIL mrst_busy2: got %b want 1", BUSY); else n_pass++;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        n_total++; if (CONTROLOUT !== 5'b00000) $display("FAIL mrst_ctrl: got %b want 00000", CONTROLOUT); else n_pass++;
        n_total++; if (BUSY !== 1'b0) $display("FAIL mrst_busy: got %b want 0", BUSY); else n_pass++;
        n_total++; if (DONE !== 1'b0) $display("FAIL mrst_done: got %b want 0", DONE); else n_pass++;
        n_total++; if (ILLEGAL !== 1'b0) $display("FAIL mrst_illegal: got %b want 0", ILLEGAL); else n_pass++;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (DONE === 1'b1 || BUSY === 1'b1) done_seen++;
        end
        n_total++; if (done_seen !== 0) $display("FAIL mrst_no_done: got %0d activity cycles want 0", done_seen); else n_pass++;
    endtask
`else
    task automatic test_no_m();
        drive(1'b1, 4'd7, OP_REG, 3'b111, F7_BASE);
        tick();
        drive(1'b1, 4'd7, OP_REG, 3'b000, F7_MULDIV);
        tick();
        n_total++; if (CONTROLOUT !== 5'b00000) $display("FAIL nom_ctrl: got %b want 00000", CONTROLOUT); else n_pass++;
        n_total++; if (ILLEGAL !== 1'b1) $display("FAIL nom_illegal: got %b want 1", ILLEGAL); else n_pass++;
        n_total++; if (DONE !== 1'b1) $display("FAIL nom_done: got %b want 1", DONE); else n_pass++;
        n_total++; if (BUSY !== 1'b0) $display("FAIL nom_busy: got %b want 0", BUSY); else n_pass++;
        VALID = 1'b0;
        tick();
        n_total++; if (BUSY !== 1'b0) $display("FAIL nom_busy2: got %b want 0", BUSY); else n_pass++;
        n_total++; if (DONE !== 1'b0) $display("FAIL nom_done2: got %b want 0", DONE); else n_pass++;
    endtask
`endif

    initial begin
        RST = 1'b0;
        drive(1'b0, 4'd0, 7'd0, 3'd0, 7'd0);
        test_reset();
        test_rtype();
        test_hold();
        test_branch();
        test_itype();
        test_fixed_states();
        test_back_to_back();
`ifdef RV32M_EN
        test_multicycle(3'b100, 32);
        test_multicycle(3'b011, 4);
        test_mul_reset();
`else
        test_no_m();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
